bitscan_sequencer: RTL
======================

BITSCAN_SEQUENCER -- requirements
Module: bitscan_sequencer

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Port clk: input, 1 bit; system clock; all state updates on the rising edge.
REQ-003 Port reset_n: input, 1 bit; asynchronous active-low reset.
REQ-004 Port start: input, 1 bit; load request, sampled only in IDLE.
REQ-005 Port mask_in: input, 32 bits; request mask captured on an accepted start.
REQ-006 Port abort: input, 1 bit; terminates an active scan.
REQ-007 Port out_ready: input, 1 bit; consumer accepts out_idx.
REQ-008 Port out_valid: output, 1 bit; out_idx holds a pending index.
REQ-009 Port out_idx: output, 6 bits; position of the lowest set bit of the remaining mask, or 32 when the mask is empty.
REQ-010 Port busy: output, 1 bit; high in SCAN or DONE.
REQ-011 Port done: output, 1 bit; one-cycle end-of-sequence pulse.
REQ-012 Port count: output, 6 bits; number of indices transferred in the current or last sequence, range 0..32.

Function
REQ-013 The block SHALL have three states, IDLE, SCAN and DONE, held in a 2-bit state register.
REQ-014 In IDLE with start=1, the block SHALL latch mask_in into the remaining register and clear count.
REQ-015 From that IDLE start, the block SHALL go to SCAN if mask_in != 0, else to DONE.
REQ-016 start SHALL be ignored in SCAN and DONE.
REQ-017 Latency: for start accepted at edge N, out_valid SHALL be 1 after edge N+1.
REQ-018 out_idx SHALL be combinational from the remaining register: index of its lowest set bit (0..31), or 6'd32 when remaining=0.
REQ-019 out_valid SHALL equal (state==SCAN) AND NOT abort.
REQ-020 A transfer SHALL occur on a cycle where out_valid=1 and out_ready=1.
REQ-021 On a transfer, remaining SHALL become remaining AND (remaining-1), and count SHALL increment by 1.
REQ-022 If remaining has exactly one set bit at a transfer, the next state SHALL be DONE.
REQ-023 When out_ready=0 in SCAN, remaining, out_idx and count SHALL hold (stall); out_valid SHALL stay 1.
REQ-024 abort=1 in SCAN SHALL go to DONE, with no transfer in that cycle and count unchanged.
REQ-025 abort SHALL take priority over out_ready in the same cycle.
REQ-026 On the abort transition, remaining SHALL be cleared to 0.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then return to IDLE.
REQ-029 count SHALL hold its final value in IDLE until the next accepted start.
REQ-030 busy SHALL be 1 exactly when state != IDLE.
REQ-031 Indices SHALL be issued in strictly ascending order, each set bit exactly once.
REQ-032 A full mask (32'hFFFFFFFF) SHALL yield 32 transfers, with count=32 and no wrap.

Reset
REQ-033 reset_n=0 SHALL immediately, without a clock, force: state=IDLE, remaining=0, count=0.
REQ-034 During and after reset, outputs SHALL read: busy=0, out_valid=0, done=0, out_idx=32.
REQ-035 Reset asserted mid-SCAN SHALL abandon the sequence, with no done pulse.
REQ-036 After reset_n rises, the first start SHALL be accepted on the next rising edge.

Structure
REQ-037 Shared package bitscan_pkg SHALL hold the state encodings: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
REQ-038 bitscan_pkg SHALL hold the constants MASK_W=32, IDX_W=6 and NONE_IDX=6'd32.
REQ-039 There SHALL be one combinational sub-module, lsb_finder: 32-bit input, 6-bit output, 32 for zero input.
REQ-040 The sequencer SHALL instantiate lsb_finder on the remaining register.

Verification
REQ-041 Bench case, basic scan: reset, start with mask_in=32'h00000016, out_ready=1 -> out_idx 1, 2, 4 on consecutive cycles, then done pulse, count=3.
REQ-042 Bench case, empty mask: start with mask_in=0 -> next cycle done=1, out_valid never 1, count=0, out_idx=32.
REQ-043 Bench case, full mask: start with mask_in=32'hFFFFFFFF, out_ready=1 -> 32 transfers with indices 0..31, count=32, done one cycle after last transfer.
REQ-044 Bench case, backpressure: mask_in=32'h80000001, out_ready=0 for 3 cycles -> out_idx held at 0; then ready -> 0, 31; count=2.
REQ-045 Bench case, abort: mask_in=32'hF0, abort with out_ready=1 on the second SCAN cycle -> only index 4 transferred, count=1, done pulse, out_valid=0 in the abort cycle.
REQ-046 Bench case, reset mid-scan: reset_n low during SCAN of mask_in=32'hFF -> immediately busy=0, out_valid=0, count=0, no done pulse.

Source files
------------

// File: rtl/bitscan_pkg.sv
// bitscan_pkg: state encodings and widths shared by the bitscan sequencer
package bitscan_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int MASK_W = 32;
    localparam int IDX_W = 6;
    localparam logic [IDX_W-1:0] NONE_IDX = 6'd32;
endpackage

// File: rtl/bitscan_sequencer_lsb_finder.sv
// lsb_finder: index of the lowest set bit, NONE_IDX for an all-zero vector
module lsb_finder
    import bitscan_pkg::*;
(
    input  logic [MASK_W-1:0] vec,
    output logic [IDX_W-1:0]  idx
);
    always_comb begin
        idx = NONE_IDX;
        for (int i = MASK_W - 1; i >= 0; i--)
            if (vec[i]) idx = IDX_W'(i);
    end
endmodule

// File: rtl/bitscan_sequencer.sv
// bitscan_sequencer: issues the set-bit indices of a captured mask in ascending order
module bitscan_sequencer
    import bitscan_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MASK_W-1:0] mask_in,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  count
);
    state_t state, state_nxt;
    logic [MASK_W-1:0] remaining, rem_nxt;
    logic [IDX_W-1:0] cnt_nxt;
    logic xfer;

    lsb_finder u_lsb (.vec(remaining), .idx(out_idx));

    assign out_valid = state == SCAN && !abort;
    assign xfer = out_valid && out_ready;
    assign busy = state != IDLE;
    assign done = state == DONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            remaining <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            remaining <= rem_nxt;
            count <= cnt_nxt;
        end
    end

    // clearing the lowest set bit; the last bit leaves remaining empty and ends the scan
    always_comb begin
        state_nxt = state;
        rem_nxt = remaining;
        cnt_nxt = count;
        if (state == IDLE && start) begin
            rem_nxt = mask_in;
            cnt_nxt = '0;
            state_nxt = mask_in != '0 ? SCAN : DONE;
        end else if (state == SCAN && abort) begin
            rem_nxt = '0;
            state_nxt = DONE;
        end else if (xfer) begin
            rem_nxt = remaining & (remaining - MASK_W'(1));
            cnt_nxt = count + IDX_W'(1);
            state_nxt = rem_nxt == '0 ? DONE : SCAN;
        end else if (state == DONE) begin
            state_nxt = IDLE;
        end
    end
endmodule
